lc3_mmio_mem: RTL and testbench

LC3_MMIO_MEM -- requirements
Module: lc3_mmio_mem

---
 rtl/lc3_pkg.sv | 23 ++
 rtl/lc3_mmio_regs.sv | 122 ++++++++++++
 rtl/lc3_mmio_mem.sv | 92 +++++++++
 tb/tb_lc3_mmio_mem.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared constants and FSM state types for the LC-3 memory and MMIO block.
// Imported by the top-level memory and the device-register sub-module.
package lc3_pkg;

  localparam logic [15:0] IO_BASE   = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
  localparam logic [15:0] RST_8000  = 16'h8000;

  typedef enum logic {
    KB_EMPTY = 1'b0,
    KB_FULL  = 1'b1
  } kb_state_t;

  typedef enum logic {
    DISP_IDLE = 1'b0,
    DISP_BUSY = 1'b1
  } disp_state_t;

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 device registers: keyboard (KBSR/KBDR), display (DSR/DDR) and machine control (MCR).
// Register values are presented combinationally; the top registers the CPU read data.
module lc3_mmio_regs
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic        kb_ready,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic        kb_irq,
  output logic        halt,
  output logic [15:0] kbsr,
  output logic [15:0] kbdr,
  output logic [15:0] dsr,
  output logic [15:0] ddr,
  output logic [15:0] mcr
);

  kb_state_t   r_kb_state, w_kb_next;
  disp_state_t r_disp_state, w_disp_next;

  logic [7:0]  r_kbdr;
  logic        r_kb_ie;
  logic [7:0]  r_ddr;
  logic [15:0] r_mcr;

  logic w_kb_capture;
  logic w_disp_latch;
  logic w_rd_kbdr;
  logic w_wr_kbsr;
  logic w_wr_ddr;
  logic w_wr_mcr;

  assign w_rd_kbdr = rd_en && (addr == KBDR_ADDR);
  assign w_wr_kbsr = wr_en && (addr == KBSR_ADDR);
  assign w_wr_ddr  = wr_en && (addr == DDR_ADDR);
  assign w_wr_mcr  = wr_en && (addr == MCR_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_kb_state   <= KB_EMPTY;
      r_disp_state <= DISP_IDLE;
    end else begin
      r_kb_state   <= w_kb_next;
      r_disp_state <= w_disp_next;
    end
  end

  // A KBDR read in FULL frees the buffer at the same edge that returns the byte.
  always_comb begin
    w_kb_next    = r_kb_state;
    w_kb_capture = 1'b0;
    case (r_kb_state)
      KB_EMPTY: begin
        if (kb_valid) begin
          w_kb_capture = 1'b1;
          w_kb_next    = KB_FULL;
        end
      end
      KB_FULL: begin
        if (w_rd_kbdr) begin
          w_kb_next = KB_EMPTY;
        end
      end
      default: w_kb_next = KB_EMPTY;
    endcase
  end

  always_comb begin
    w_disp_next  = r_disp_state;
    w_disp_latch = 1'b0;
    case (r_disp_state)
      DISP_IDLE: begin
        if (w_wr_ddr) begin
          w_disp_latch = 1'b1;
          w_disp_next  = DISP_BUSY;
        end
      end
      DISP_BUSY: begin
        if (disp_ready) begin
          w_disp_next = DISP_IDLE;
        end
      end
      default: w_disp_next = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_kbdr  <= 8'h00;
      r_kb_ie <= 1'b0;
      r_ddr   <= 8'h00;
      r_mcr   <= RST_8000;
    end else begin
      if (w_kb_capture) r_kbdr  <= kb_data;
      if (w_wr_kbsr)    r_kb_ie <= wdata[14];
      if (w_disp_latch) r_ddr   <= wdata[7:0];
      if (w_wr_mcr)     r_mcr   <= wdata;
    end
  end

  assign kbsr = {(r_kb_state == KB_FULL), r_kb_ie, 14'h0000};
  assign kbdr = {8'h00, r_kbdr};
  assign dsr  = {(r_disp_state == DISP_IDLE), 15'h0000};
  assign ddr  = {8'h00, r_ddr};
  assign mcr  = r_mcr;

  assign kb_ready   = (r_kb_state == KB_EMPTY);
  assign kb_irq     = kbsr[15] & kbsr[14];
  assign disp_valid = (r_disp_state == DISP_BUSY);
  assign disp_data  = r_ddr;
  assign halt       = ~r_mcr[15];

endmodule

// File: rtl/lc3_mmio_mem.sv
// LC-3 word memory with memory-mapped keyboard, display and MCR registers.
// Holds the storage array and the registered CPU read mux.
module lc3_mmio_mem
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] ram_data,
  output logic [15:0] mem_data,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic        kb_ready,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic        kb_irq,
  output logic        halt
);

  logic [15:0] mem [0:(2**ADDR_W)-1];

  logic [15:0]       r_mem_data;
  logic              w_is_io;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_idx;
  logic [15:0]       w_io_rdata;
  logic [15:0]       w_kbsr, w_kbdr, w_dsr, w_ddr, w_mcr;

  assign w_is_io = (mem_addr >= IO_BASE);
  assign w_rd    = mem_en & ~we;
  assign w_wr    = mem_en & we;
  assign w_idx   = mem_addr[ADDR_W-1:0];

  lc3_mmio_regs u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (w_rd),
    .wr_en      (w_wr),
    .addr       (mem_addr),
    .wdata      (ram_data),
    .kb_data    (kb_data),
    .kb_valid   (kb_valid),
    .kb_ready   (kb_ready),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .kb_irq     (kb_irq),
    .halt       (halt),
    .kbsr       (w_kbsr),
    .kbdr       (w_kbdr),
    .dsr        (w_dsr),
    .ddr        (w_ddr),
    .mcr        (w_mcr)
  );

  // Unmapped I/O addresses read as zero.
  always_comb begin
    w_io_rdata = 16'h0000;
    case (mem_addr)
      KBSR_ADDR: w_io_rdata = w_kbsr;
      KBDR_ADDR: w_io_rdata = w_kbdr;
      DSR_ADDR:  w_io_rdata = w_dsr;
      DDR_ADDR:  w_io_rdata = w_ddr;
      MCR_ADDR:  w_io_rdata = w_mcr;
      default:   w_io_rdata = 16'h0000;
    endcase
  end

  // No reset on the array so preloaded contents survive; writes are gated by rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr && !w_is_io) begin
      mem[w_idx] <= ram_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_data <= 16'h0000;
    end else if (w_rd) begin
      r_mem_data <= w_is_io ? w_io_rdata : mem[w_idx];
    end
  end

  assign mem_data = r_mem_data;

endmodule

// File: tb/tb_lc3_mmio_mem.sv
// Directed, table-driven bench for lc3_mmio_mem (ADDR_W=8 so address wrap is visible).
// Each vector is one clock: inputs applied before the edge, outputs checked 1 time unit after.
module tb_lc3_mmio_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en;
  logic        we;
  logic [15:0] mem_addr;
  logic [15:0] ram_data;
  logic [15:0] mem_data;
  logic [7:0]  kb_data;
  logic        kb_valid;
  logic        kb_ready;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        disp_ready;
  logic        kb_irq;
  logic        halt;

  int n_cmp  = 0;
  int n_fail = 0;

  lc3_mmio_mem #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_en     (mem_en),
    .we         (we),
    .mem_addr   (mem_addr),
    .ram_data   (ram_data),
    .mem_data   (mem_data),
    .kb_data    (kb_data),
    .kb_valid   (kb_valid),
    .kb_ready   (kb_ready),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .kb_irq     (kb_irq),
    .halt       (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        kbv;
    logic [7:0]  kbd;
    logic        drdy;
    logic [15:0] e_md;
    logic        e_kbr;
    logic        e_dv;
    logic [7:0]  e_dd;
    logic        e_irq;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic w, logic [15:0] a, logic [15:0] d,
                              logic kv, logic [7:0] kd, logic dr, logic [15:0] md,
                              logic kr, logic dv, logic [7:0] dd, logic irq, logic hl);
    vec_t v;
    v.rst_n = r;  v.en = e;   v.we = w;     v.addr = a;  v.wdata = d;
    v.kbv = kv;   v.kbd = kd; v.drdy = dr;  v.e_md = md; v.e_kbr = kr;
    v.e_dv = dv;  v.e_dd = dd; v.e_irq = irq; v.e_halt = hl;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_en = 1'b0; we = 1'b0; mem_addr = 16'h0000; ram_data = 16'h0000;
    kb_data = 8'h00; kb_valid = 1'b0; disp_ready = 1'b0;
    // Word address x3000 maps to index x00 with an 8-bit array index.
    dut.mem[0] = 16'h1234;

    //             rst en we addr     wdata    kbv kbd    drdy  mem_data kbr dv disp_data irq halt
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0, 0)); // 0 reset
    vecs.push_back(mk(1, 1, 0, 16'h3000, 16'h0000, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 0, 0)); // 1 read preload
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 0, 0)); // 2 hold
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 0, 0)); // 3 hold
    vecs.push_back(mk(1, 0, 1, 16'h0000, 16'h0000, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 0, 0)); // 4 hold, we without en
    vecs.push_back(mk(1, 1, 1, 16'h0010, 16'h00AB, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 0, 0)); // 5 write x0010
    vecs.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 0, 8'h00, 0, 16'h00AB, 1, 0, 8'h00, 0, 0)); // 6 read back
    vecs.push_back(mk(1, 1, 0, 16'h0110, 16'h0000, 0, 8'h00, 0, 16'h00AB, 1, 0, 8'h00, 0, 0)); // 7 wrap read
    vecs.push_back(mk(1, 1, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 0, 0)); // 8 DSR reset
    vecs.push_back(mk(1, 1, 0, 16'hFFFE, 16'h0000, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 0, 0)); // 9 MCR reset
    vecs.push_back(mk(1, 1, 1, 16'hFE10, 16'hFFFF, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 0, 0)); // 10 unmapped wr
    vecs.push_back(mk(1, 1, 0, 16'hFE10, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0, 0)); // 11 unmapped rd
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 8'h41, 0, 16'h0000, 0, 0, 8'h00, 0, 0)); // 12 kb byte x41
    vecs.push_back(mk(1, 1, 0, 16'hFE00, 16'h0000, 1, 8'h42, 0, 16'h8000, 0, 0, 8'h00, 0, 0)); // 13 x42 refused
    vecs.push_back(mk(1, 1, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 16'h0041, 1, 0, 8'h00, 0, 0)); // 14 read KBDR
    vecs.push_back(mk(1, 1, 0, 16'hFE00, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0, 0)); // 15 KBSR empty
    vecs.push_back(mk(1, 1, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 16'h0041, 1, 0, 8'h00, 0, 0)); // 16 stale KBDR
    vecs.push_back(mk(1, 1, 1, 16'hFE00, 16'hFFFF, 0, 8'h00, 0, 16'h0041, 1, 0, 8'h00, 0, 0)); // 17 write KBSR
    vecs.push_back(mk(1, 1, 0, 16'hFE00, 16'h0000, 0, 8'h00, 0, 16'h4000, 1, 0, 8'h00, 0, 0)); // 18 only IE set
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 8'h5A, 0, 16'h4000, 0, 0, 8'h00, 1, 0)); // 19 irq
    vecs.push_back(mk(1, 1, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 16'h005A, 1, 0, 8'h00, 0, 0)); // 20 irq clears
    vecs.push_back(mk(1, 1, 1, 16'hFE00, 16'h0000, 0, 8'h00, 0, 16'h005A, 1, 0, 8'h00, 0, 0)); // 21 IE off
    vecs.push_back(mk(1, 1, 1, 16'hFE06, 16'h0058, 0, 8'h00, 0, 16'h005A, 1, 1, 8'h58, 0, 0)); // 22 DDR=x58
    vecs.push_back(mk(1, 1, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h58, 0, 0)); // 23 DSR busy
    vecs.push_back(mk(1, 1, 1, 16'hFE06, 16'h0059, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h58, 0, 0)); // 24 dropped
    vecs.push_back(mk(1, 1, 0, 16'hFE06, 16'h0000, 0, 8'h00, 0, 16'h0058, 1, 1, 8'h58, 0, 0)); // 25 read DDR
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 1, 16'h0058, 1, 0, 8'h58, 0, 0)); // 26 transfer
    vecs.push_back(mk(1, 1, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h58, 0, 0)); // 27 DSR idle
    vecs.push_back(mk(1, 1, 1, 16'hFE04, 16'h0000, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h58, 0, 0)); // 28 DSR write
    vecs.push_back(mk(1, 1, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h58, 0, 0)); // 29 ignored
    vecs.push_back(mk(1, 1, 1, 16'hFFFE, 16'h0000, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h58, 0, 1)); // 30 MCR=0
    vecs.push_back(mk(1, 1, 0, 16'hFFFE, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h58, 0, 1)); // 31 read MCR
    vecs.push_back(mk(1, 1, 1, 16'hFE06, 16'h0077, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h77, 0, 1)); // 32 go BUSY
    vecs.push_back(mk(0, 1, 1, 16'h0010, 16'hFFFF, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0, 0)); // 33 rst mid-BUSY
    vecs.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 0, 8'h00, 0, 16'h00AB, 1, 0, 8'h00, 0, 0)); // 34 mem kept
    vecs.push_back(mk(1, 1, 0, 16'h3000, 16'h0000, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 0, 0)); // 35 preload kept
    vecs.push_back(mk(1, 1, 0, 16'hFFFE, 16'h0000, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 0, 0)); // 36 MCR reset
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 8'h33, 0, 16'h8000, 0, 0, 8'h00, 0, 0)); // 37 kb FULL
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0, 0)); // 38 rst in FULL
    vecs.push_back(mk(1, 1, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0, 0)); // 39 KBDR gone

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n      = vecs[i].rst_n;
      mem_en     = vecs[i].en;
      we         = vecs[i].we;
      mem_addr   = vecs[i].addr;
      ram_data   = vecs[i].wdata;
      kb_valid   = vecs[i].kbv;
      kb_data    = vecs[i].kbd;
      disp_ready = vecs[i].drdy;
      tick();
      $display("vec %0d: rst_n=%b en=%b we=%b addr=%h wdata=%h -> mem_data=%h kb_ready=%b disp_valid=%b disp_data=%h kb_irq=%b halt=%b",
               i, rst_n, mem_en, we, mem_addr, ram_data, mem_data, kb_ready, disp_valid, disp_data, kb_irq, halt);
      check($sformatf("v%0d mem_data", i),   mem_data,          vecs[i].e_md);
      check($sformatf("v%0d kb_ready", i),   {15'h0, kb_ready}, {15'h0, vecs[i].e_kbr});
      check($sformatf("v%0d disp_valid", i), {15'h0, disp_valid}, {15'h0, vecs[i].e_dv});
      check($sformatf("v%0d disp_data", i),  {8'h0, disp_data}, {8'h0, vecs[i].e_dd});
      check($sformatf("v%0d kb_irq", i),     {15'h0, kb_irq},   {15'h0, vecs[i].e_irq});
      check($sformatf("v%0d halt", i),       {15'h0, halt},     {15'h0, vecs[i].e_halt});
    end

    // Sink always ready: a DDR write must yield exactly one one-cycle transfer.
    begin
      int xfers;
      rst_n = 1'b1; kb_valid = 1'b0; disp_ready = 1'b1;
      mem_en = 1'b1; we = 1'b1; mem_addr = 16'hFE06; ram_data = 16'hFF21;
      tick();
      $display("seq ddr write x21 with sink ready -> disp_valid=%b disp_data=%h", disp_valid, disp_data);
      check("seq disp_valid after write", {15'h0, disp_valid}, 16'h0001);
      check("seq disp_data", {8'h0, disp_data}, 16'h0021);
      mem_en = 1'b0; we = 1'b0;
      xfers = 0;
      for (int c = 0; c < 6; c++) begin
        if (disp_valid && disp_ready) xfers++;
        tick();
      end
      $display("seq transfers counted=%0d", xfers);
      check("seq transfer count", 16'(xfers), 16'h0001);
      check("seq disp_valid idle", {15'h0, disp_valid}, 16'h0000);
    end

    // A KBDR read in FULL must not lose a byte offered in the very next cycle.
    begin
      kb_valid = 1'b1; kb_data = 8'h61;
      tick();
      kb_valid = 1'b1; kb_data = 8'h62; mem_en = 1'b1; we = 1'b0; mem_addr = 16'hFE02;
      tick();
      check("seq kbdr first byte", mem_data, 16'h0061);
      check("seq kb_ready after read", {15'h0, kb_ready}, 16'h0001);
      mem_en = 1'b0;
      tick();
      check("seq kb_ready refill", {15'h0, kb_ready}, 16'h0000);
      kb_valid = 1'b0; mem_en = 1'b1; mem_addr = 16'hFE02;
      tick();
      $display("seq second kb byte -> mem_data=%h kb_ready=%b", mem_data, kb_ready);
      check("seq kbdr second byte", mem_data, 16'h0062);
      mem_en = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
